// File: rtl/dispatcher_rd_sequencer.sv
// dispatcher_rd_sequencer
//   Walks two group buffers (left/right) for one command and streams the
//   matching mantissa lines and group exponents to the compute engine.
//   A command names a base address per side and a group count. Read k uses
//   (base + k) mod 2^ADDR_WIDTH on each side. Buffers return data one cycle
//   after the address is issued. Captured beats queue in a small output FIFO.
//   Reads are credit-limited so the FIFO can never overflow.
//
// Ports
//   i_clk, i_reset              clock, synchronous active-high reset
//   i_start, i_*_base,
//   i_num_groups                command strobe and arguments (count clamped to 2^ADDR_WIDTH)
//   o_busy, o_done              command in progress / one-cycle completion pulse
//   o_rd_addr_*, o_rd_en_*      mantissa buffer read port (both sides issue together)
//   o_*_exp_rd_addr             exponent buffer addresses (mirror the mantissa address)
//   i_rd_data_*, i_*_exp_rd_data buffer read data, valid the cycle after issue
//   o_valid / i_ready           output beat handshake
//   o_*_man, o_*_exp,
//   o_group_idx, o_last         beat payload from the FIFO head
module dispatcher_rd_sequencer #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_left_base,
  input  logic [ADDR_WIDTH-1:0] i_right_base,
  input  logic [ADDR_WIDTH:0]   i_num_groups,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_left,
  output logic [ADDR_WIDTH-1:0] o_rd_addr_right,
  output logic                  o_rd_en_left,
  output logic                  o_rd_en_right,
  input  logic [DATA_WIDTH-1:0] i_rd_data_left,
  input  logic [DATA_WIDTH-1:0] i_rd_data_right,
  output logic [ADDR_WIDTH-1:0] o_left_exp_rd_addr,
  output logic [ADDR_WIDTH-1:0] o_right_exp_rd_addr,
  input  logic [7:0]            i_left_exp_rd_data,
  input  logic [7:0]            i_right_exp_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_left_man,
  output logic [DATA_WIDTH-1:0] o_right_man,
  output logic [7:0]            o_left_exp,
  output logic [7:0]            o_right_exp,
  output logic [ADDR_WIDTH:0]   o_group_idx,
  output logic                  o_last
);

  localparam int CW  = ADDR_WIDTH + 1;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OW  = $clog2(FIFO_DEPTH + 1);
  localparam int OW1 = OW + 1;
  localparam logic [CW-1:0] MAX_GROUPS = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] lman;
    logic [DATA_WIDTH-1:0] rman;
    logic [7:0]            lexp;
    logic [7:0]            rexp;
    logic [CW-1:0]         idx;
    logic                  last;
  } entry_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] lbase_q, lbase_d;
  logic [ADDR_WIDTH-1:0] rbase_q, rbase_d;
  logic [CW-1:0]         num_q, num_d;
  logic [CW-1:0]         issue_cnt_q, issue_cnt_d;
  logic                  inflight_q, inflight_d;
  logic [CW-1:0]         inflight_idx_q, inflight_idx_d;
  logic                  inflight_last_q, inflight_last_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  entry_t                mem_q [FIFO_DEPTH];
  entry_t                mem_d [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]         occ_q, occ_d;

  logic                  valid, pop, push, issue, last_issue, start_ok, drain_done;
  logic [CW-1:0]         num_clamped;
  logic [OW1-1:0]        credit_used, credit_lim;
  logic [ADDR_WIDTH-1:0] addr_left, addr_right;
  entry_t                head, push_entry;

  assign valid      = (occ_q != '0);
  assign pop        = valid & i_ready;
  assign head       = mem_q[rd_ptr_q];
  // The buffer answers one cycle after issue, so the in-flight flag is the push.
  assign push       = inflight_q;
  assign start_ok   = i_start & (state_q == S_IDLE) & ~busy_q;
  assign drain_done = (state_q == S_DRAIN) & pop & head.last;
  assign num_clamped = (i_num_groups > MAX_GROUPS) ? MAX_GROUPS : i_num_groups;
  assign last_issue  = (issue_cnt_q == num_q - CW'(1));

  // Issue only if the beat is guaranteed a FIFO slot when it lands. Adding
  // the pop to the limit side keeps the compare unsigned-safe.
  assign credit_used = OW1'(occ_q) + OW1'(inflight_q);
  assign credit_lim  = OW1'(FIFO_DEPTH) + OW1'(pop);
  assign issue       = (state_q == S_RUN) && (credit_used < credit_lim);

  // Address arithmetic wraps naturally at the buffer size.
  assign addr_left  = lbase_q + issue_cnt_q[ADDR_WIDTH-1:0];
  assign addr_right = rbase_q + issue_cnt_q[ADDR_WIDTH-1:0];

  always_comb begin
    push_entry      = '0;
    push_entry.lman = i_rd_data_left;
    push_entry.rman = i_rd_data_right;
    push_entry.lexp = i_left_exp_rd_data;
    push_entry.rexp = i_right_exp_rd_data;
    push_entry.idx  = inflight_idx_q;
    push_entry.last = inflight_last_q;
  end

  // Command FSM and read sequencing
  always_comb begin
    state_d         = state_q;
    lbase_d         = lbase_q;
    rbase_d         = rbase_q;
    num_d           = num_q;
    issue_cnt_d     = issue_cnt_q;
    done_d          = 1'b0;
    inflight_d      = issue;
    inflight_idx_d  = issue_cnt_q;
    inflight_last_d = last_issue;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          if (num_clamped == '0) begin
            done_d = 1'b1;
          end else begin
            lbase_d     = i_left_base;
            rbase_d     = i_right_base;
            num_d       = num_clamped;
            issue_cnt_d = '0;
            state_d     = S_RUN;
          end
        end
      end
      S_RUN: begin
        if (issue) begin
          issue_cnt_d = issue_cnt_q + CW'(1);
          if (last_issue) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Busy stays up through the done pulse of a real command; an empty
    // command completes without ever going busy.
    busy_d = (state_d != S_IDLE) | drain_done;
  end

  // Output FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    end
    occ_d = occ_q + OW'(push) - OW'(pop);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q         <= S_IDLE;
      lbase_q         <= '0;
      rbase_q         <= '0;
      num_q           <= '0;
      issue_cnt_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_idx_q  <= '0;
      inflight_last_q <= 1'b0;
      done_q          <= 1'b0;
      busy_q          <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      occ_q           <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      lbase_q         <= lbase_d;
      rbase_q         <= rbase_d;
      num_q           <= num_d;
      issue_cnt_q     <= issue_cnt_d;
      inflight_q      <= inflight_d;
      inflight_idx_q  <= inflight_idx_d;
      inflight_last_q <= inflight_last_d;
      done_q          <= done_d;
      busy_q          <= busy_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      occ_q           <= occ_d;
      mem_q           <= mem_d;
    end
  end

  assign o_busy              = busy_q;
  assign o_done              = done_q;
  assign o_rd_en_left        = issue;
  assign o_rd_en_right       = issue;
  assign o_rd_addr_left      = addr_left;
  assign o_rd_addr_right     = addr_right;
  assign o_left_exp_rd_addr  = addr_left;
  assign o_right_exp_rd_addr = addr_right;
  assign o_valid             = valid;
  assign o_left_man          = head.lman;
  assign o_right_man         = head.rman;
  assign o_left_exp          = head.lexp;
  assign o_right_exp         = head.rexp;
  assign o_group_idx         = head.idx;
  assign o_last              = head.last;

endmodule

// File: doc/dispatcher_rd_sequencer.md
DISPATCHER_RD_SEQUENCER -- requirements
Module: dispatcher_rd_sequencer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning): DATA_WIDTH, 256, mantissa line width; ADDR_WIDTH, 9, buffer address width (512 lines); FIFO_DEPTH, 2, output FIFO entries.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset; ports are listed as name, direction, width, meaning.
- i_clk  in  1  sole clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  one-cycle command strobe.
- i_left_base  in  9  first left group address.
- i_right_base  in  9  first right group address.
- i_num_groups  in  10  group count, 0..512.
- o_busy  out  1  command in progress.
- o_done  out  1  one-cycle completion pulse.
- o_rd_addr_left, o_rd_addr_right  out  9 each  mantissa read addresses.
- o_rd_en_left, o_rd_en_right  out  1 each  mantissa read enables.
- i_rd_data_left, i_rd_data_right  in  DATA_WIDTH each  mantissa read data.
- o_left_exp_rd_addr, o_right_exp_rd_addr  out  9 each  exponent read addresses.
- i_left_exp_rd_data, i_right_exp_rd_data  in  8 each  exponent read data.
- o_valid  out  1  output beat valid.
- i_ready  in  1  compute engine accepts the beat.
- o_left_man, o_right_man  out  DATA_WIDTH each  mantissa lines.
- o_left_exp, o_right_exp  out  8 each  group exponents.
- o_group_idx  out  10  beat index within the command, 0-based.
- o_last  out  1  final beat of the command.

Function
REQ-003 Buffer read timing: registered, 1-cycle latency; data for an address issued in cycle N SHALL be captured in cycle N+1; the exponent address SHALL always equal the mantissa address of the same side.
REQ-004 The FSM SHALL have three states: IDLE, RUN, DRAIN.
REQ-005 In IDLE, i_start with i_num_groups in 1..512 SHALL latch both bases and the count, clear the counters, and enter RUN.
REQ-006 In IDLE, i_start with i_num_groups=0 SHALL pulse o_done on the next cycle, issue no reads, and remain in IDLE.
REQ-007 i_start while o_busy=1 SHALL be ignored; the latched command SHALL be unaffected.
REQ-008 i_num_groups > 512 SHALL be clamped to 512.
REQ-009 In RUN, a read SHALL be issued in a cycle only when (FIFO occupancy + reads in flight - pop this cycle) < FIFO_DEPTH; both rd_en signals SHALL assert together.
REQ-010 Read k (0-based) SHALL use address (base + k) mod 512 per side; wrap from 511 to 0 is legal.
REQ-011 The rd_en signals SHALL be deasserted in any cycle with no issue.
REQ-012 Captured data SHALL be pushed into the FIFO in issue order; each entry SHALL hold both mantissas, both exponents, the group index, and the last flag.
REQ-013 The FSM SHALL go from RUN to DRAIN in the cycle after the final read issues.
REQ-014 The FSM SHALL go from DRAIN to IDLE when the beat with o_last=1 is accepted (o_valid & i_ready); o_done SHALL pulse in the following cycle.
REQ-015 o_valid SHALL equal FIFO-not-empty, and output fields SHALL come from the FIFO head.
REQ-016 Outputs SHALL be held stable while o_valid=1 and i_ready=0.
REQ-017 Pop and push in the same cycle SHALL be legal at any occupancy, including full.
REQ-018 With i_ready held high, throughput SHALL be 1 beat/cycle; the first o_valid SHALL assert 3 cycles after the i_start cycle.
REQ-019 o_busy SHALL be 1 from the cycle after an accepted i_start through the cycle o_done pulses.
REQ-020 o_last SHALL be 1 only on beat index i_num_groups-1.

Reset
REQ-021 While i_reset=1, the FSM SHALL go to IDLE, the FIFO and in-flight tracking SHALL be emptied, and all counters SHALL be cleared.
REQ-022 Reset values SHALL be: o_busy=0, o_done=0, o_valid=0, rd_en=0, all addresses=0, o_group_idx=0, o_last=0; data outputs SHALL be 0.
REQ-023 Reset mid-command SHALL discard the command with no o_done pulse; the next i_start SHALL behave as from power-up.

Verification
REQ-024 Bases 0/0, count 4, i_ready=1 -> addresses 0,1,2,3 on consecutive cycles; beats with idx 0..3 on consecutive cycles starting 3 cycles after start; o_last on idx 3; o_done one cycle after.
REQ-025 Bases 510/5, count 4 -> left addresses 510,511,0,1 and right addresses 5,6,7,8; data matches the model.
REQ-026 Count 8, i_ready random at 50% -> no beat lost or duplicated; outputs stable while stalled; occupancy never exceeds 2.
REQ-027 Count 0 -> o_done pulse one cycle after start; no rd_en; o_valid stays 0.
REQ-028 Count 512, i_ready=1 -> 512 beats in 512 consecutive cycles; second i_start during the run ignored.
REQ-029 Reset asserted after beat 2 of 6 -> all outputs return to reset values; no o_done; a new count-2 command completes correctly.
